// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light sequencer and light FSM.
// State encoding, light count and LFSR constants.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  localparam int         NUM_LIGHTS = 8;
  localparam logic [6:0] LFSR_SEED  = 7'h01;
  localparam logic [6:0] LFSR_TAPS  = 7'h60;

endpackage

// File: rtl/f1_sequencer_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR, x^7+x^6+1.
// Seeded non-zero on reset, so it never locks up at 0.
module lfsr7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  logic [6:0] q_q;
  logic [6:0] q_d;

  // Shift left, feed back the XOR of the tapped bits.
  always_comb begin
    q_d = {q_q[5:0], ^(q_q & LFSR_TAPS)};
  end

  // Advance every cycle in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/f1_sequencer.sv
// Strobe generator for the F1 start-light FSM.
// Lights on one per tick, random hold, then one lights-out strobe.
module f1_sequencer #(
  parameter int CNT_W      = 16,
  parameter int NUM_LIGHTS = f1_pkg::NUM_LIGHTS,
  parameter int LFSR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  n,
  output logic              en,
  output logic              lights_out,
  output logic              busy,
  output logic [LFSR_W-1:0] delay_ticks
);

  import f1_pkg::*;

  localparam int LW = $clog2(NUM_LIGHTS + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LW-1:0]     lights_q, lights_d;
  logic [LFSR_W-1:0] dly_q, dly_d;
  logic [LFSR_W-1:0] dtk_q, dtk_d;
  logic [6:0]        lfsr;
  logic              tick;
  logic              last;

  lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign tick = (state_q != IDLE) && (cnt_q == '0);
  assign last = (state_q == HOLD) && (dly_q == LFSR_W'(1));

  assign en          = tick && ((state_q == COUNT) || last);
  assign lights_out  = tick && last;
  assign busy        = (state_q != IDLE);
  assign delay_ticks = dtk_q;

  // Next-state: period counter, light count, hold countdown.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lights_d = lights_q;
    dly_d    = dly_q;
    dtk_d    = dtk_q;
    if (state_q != IDLE) begin
      cnt_d = tick ? n : cnt_q - CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = COUNT;
          cnt_d    = n;
          lights_d = '0;
        end
      end
      COUNT: begin
        if (tick) begin
          lights_d = lights_q + LW'(1);
          if (lights_q == LW'(NUM_LIGHTS - 1)) begin
            state_d = HOLD;
            dly_d   = LFSR_W'(lfsr);
            dtk_d   = LFSR_W'(lfsr);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          dly_d = dly_q - LFSR_W'(1);
          if (last) begin
            state_d = IDLE;
            dtk_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset returns to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lights_q <= '0;
      dly_q    <= '0;
      dtk_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lights_q <= lights_d;
      dly_q    <= dly_d;
      dtk_q    <= dtk_d;
    end
  end

endmodule

// File: tb/tb_f1_sequencer.sv
// Self-checking bench for f1_sequencer.
// Expected strobe cycles are queued at stimulus time, compared to observed.
module tb_f1_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [15:0] n;
  logic        en;
  logic        lights_out;
  logic        busy;
  logic [6:0]  delay_ticks;

  typedef struct {
    int cyc;
    bit lo;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  logic [6:0] m_lfsr;
  logic [7:0] lf;

  always #5 clk = ~clk;

  f1_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .n           (n),
    .en          (en),
    .lights_out  (lights_out),
    .busy        (busy),
    .delay_ticks (delay_ticks)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  always @(posedge clk or posedge rst) begin
    if (rst)     lf <= 8'h00;
    else if (en) lf <= lights_out ? 8'h00 : {lf[6:0], 1'b1};
  end

  always @(negedge clk) begin
    if (!rst && (en || lights_out)) obs_q.push_back('{cyc, lights_out});
  end

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    trigger = 1'b0;
    n = 16'd3;
    #1;
    checks++;
    if ({en, lights_out, busy, delay_ticks} !== 10'b0)
      $display("FAIL reset_outputs: got %b required 0", {en, lights_out, busy, delay_ticks});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dut.lfsr !== 7'h01) $display("FAIL reset_lfsr: got %h required 01", dut.lfsr);
    else passes++;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (en !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_pre_en: got en=%b busy=%b required 1 1", en, busy);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({en, lights_out, busy, delay_ticks} !== 10'b0)
      $display("FAIL reset_async: got %b required 0", {en, lights_out, busy, delay_ticks});
    else passes++;
    obs_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dut.lfsr !== 7'h01) $display("FAIL reset_lfsr_rel: got %h required 01", dut.lfsr);
    else passes++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || obs_q.size() != 0)
      $display("FAIL reset_no_resume: busy %0d cycles, en %0d, required 0 0", bad, obs_q.size());
    else passes++;
  endtask

  task automatic test_count();
    int t, c8, l, d, bad;
    ev_t e, o;
    exp_q.delete();
    obs_q.delete();
    n = 16'd3;
    @(negedge clk);
    trigger = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 1; i <= 8; i++) exp_q.push_back('{t + i * 4 - 1, 1'b0});
    c8 = t + 31;
    bad = 0;
    while (cyc < c8) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
      if (cyc == t + 5) begin
        checks++;
        if (delay_ticks !== 7'd0) $display("FAIL count_dtk0: got %0d required 0", delay_ticks);
        else passes++;
      end
    end
    d = int'(m_lfsr);
    @(negedge clk);
    checks++;
    if (delay_ticks !== 7'(d)) $display("FAIL count_dtk: got %0d required %0d", delay_ticks, d);
    else passes++;
    checks++;
    if (lf !== 8'hFF) $display("FAIL count_lights: got %h required ff", lf);
    else passes++;
    l = c8 + d * 4;
    exp_q.push_back('{l, 1'b1});
    while (cyc < l) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL count_busy: got %0d low cycles required 0", bad);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || delay_ticks !== 7'd0 || lf !== 8'h00)
      $display("FAIL count_end: got busy=%b dtk=%0d lf=%h required 0 0 00", busy, delay_ticks, lf);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL count_sb: missing strobe, required cyc %0d", e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.lo !== e.lo)
          $display("FAIL count_sb: got cyc %0d lo %0d required cyc %0d lo %0d", o.cyc, o.lo, e.cyc, e.lo);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL count_extra: got %0d extra strobes required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int t, c8, l, d;
    ev_t e, o;
    exp_q.delete();
    obs_q.delete();
    n = 16'd0;
    @(negedge clk);
    trigger = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 1; i <= 8; i++) exp_q.push_back('{t + i - 1, 1'b0});
    c8 = t + 7;
    while (cyc < c8) @(negedge clk);
    d = int'(m_lfsr);
    l = c8 + d;
    exp_q.push_back('{l, 1'b1});
    while (cyc < l + 1) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_end: got busy=%b required 0", busy);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL b2b_sb: missing strobe, required cyc %0d", e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.lo !== e.lo)
          $display("FAIL b2b_sb: got cyc %0d lo %0d required cyc %0d lo %0d", o.cyc, o.lo, e.cyc, e.lo);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL b2b_extra: got %0d extra strobes required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_trigger();
    int t, c8, l, d, t2;
    ev_t e, o;
    exp_q.delete();
    obs_q.delete();
    n = 16'd2;
    @(negedge clk);
    trigger = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 1; i <= 8; i++) exp_q.push_back('{t + i * 3 - 1, 1'b0});
    c8 = t + 23;
    while (cyc < t + 5) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    while (cyc < c8) @(negedge clk);
    d = int'(m_lfsr);
    l = c8 + d * 3;
    exp_q.push_back('{l, 1'b1});
    @(negedge clk);
    @(negedge clk);
    trigger = 1'b1;
    t2 = l + 2;
    for (int i = 1; i <= 8; i++) exp_q.push_back('{t2 + i * 3 - 1, 1'b0});
    while (cyc < t2) @(negedge clk);
    trigger = 1'b0;
    c8 = t2 + 23;
    while (cyc < c8) @(negedge clk);
    d = int'(m_lfsr);
    l = c8 + d * 3;
    exp_q.push_back('{l, 1'b1});
    while (cyc < l + 1) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL trig_end: got busy=%b required 0", busy);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL trig_sb: missing strobe, required cyc %0d", e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.lo !== e.lo)
          $display("FAIL trig_sb: got cyc %0d lo %0d required cyc %0d lo %0d", o.cyc, o.lo, e.cyc, e.lo);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL trig_extra: got %0d extra strobes required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_n_change();
    int t, c8, l, d;
    ev_t e, o;
    exp_q.delete();
    obs_q.delete();
    n = 16'd3;
    @(negedge clk);
    trigger = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back('{t + i * 4 - 1, 1'b0});
    for (int i = 1; i <= 4; i++) exp_q.push_back('{t + 15 + i * 2, 1'b0});
    while (cyc < t + 12) @(negedge clk);
    n = 16'd1;
    c8 = t + 23;
    while (cyc < c8) @(negedge clk);
    d = int'(m_lfsr);
    @(negedge clk);
    checks++;
    if (lf !== 8'hFF) $display("FAIL nchg_lights: got %h required ff", lf);
    else passes++;
    l = c8 + d * 2;
    exp_q.push_back('{l, 1'b1});
    while (cyc < l + 1) @(negedge clk);
    checks++;
    if (lf !== 8'h00 || busy !== 1'b0)
      $display("FAIL nchg_end: got lf=%h busy=%b required 00 0", lf, busy);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL nchg_sb: missing strobe, required cyc %0d", e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.lo !== e.lo)
          $display("FAIL nchg_sb: got cyc %0d lo %0d required cyc %0d lo %0d", o.cyc, o.lo, e.cyc, e.lo);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL nchg_extra: got %0d extra strobes required 0", obs_q.size());
    else passes++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count();
    test_back_to_back();
    test_trigger();
    test_n_change();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
